vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Raster timing generator for the 800x600 panel path.
- Divides the system clock into a pixel-tick enable and runs the horizontal/vertical counters.
- Produces registered sync, active-video and line/frame markers; the pixel-colour stage directly downstream consumes these.
- All outputs describe the same pixel and change only on a pixel tick.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- HW, 11, hcount width
- VW, 10, vcount width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes divider, counters and outputs
- pix_tick  out  1  one-clk pulse, pixel advance strobe
- hcount  out  HW  current pixel column, 0..H_TOTAL-1
- vcount  out  VW  current line, 0..V_TOTAL-1
- active  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE
- hsync  out  1  horizontal sync, SYNC_POL when asserted
- vsync  out  1  vertical sync, SYNC_POL when asserted
- line_start  out  1  one-clk pulse when hcount becomes 0
- frame_start  out  1  one-clk pulse when (hcount,vcount) becomes (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1040). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (666).
- Reset (async assert, any time): div_cnt=0, pix_tick=0, hcount=0, vcount=0, active=1, hsync=vsync=~SYNC_POL, line_start=0, frame_start=0.
- Divider: div_cnt counts 0..CLK_DIV-1 on each clk where en=1.
  - pix_tick is registered. It is 1 for the one clk after div_cnt reaches CLK_DIV-1, so the first tick is high on the CLK_DIV-th enabled edge after reset release.
  - CLK_DIV=1 gives pix_tick=1 every enabled cycle.
- Counter update on the same edge that sets pix_tick:
  - hcount==H_TOTAL-1 → hcount=0, and vcount = (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - Otherwise hcount+1, vcount unchanged.
- Output alignment: active, hsync, vsync, line_start and frame_start are registered from the next counter values on the same edge. No output lags the counters.
- hsync asserted when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (856..975).
- vsync asserted when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (637..642). vsync changes only together with the hcount wrap.
- Markers: line_start=1 for exactly one clk when hcount wraps to 0. frame_start additionally requires vcount wrap to 0. Neither pulses at reset.
- en=0: div_cnt, counters and level outputs hold. pix_tick, line_start and frame_start drive 0.
  - en deasserted on a would-be tick cycle → that tick is lost, not deferred.
  - Resuming en continues div_cnt from its held value.
- Reset mid-frame: outputs return to reset values immediately, without waiting for a clk edge. Counting restarts from (0,0) with full divider latency.
- Width rule: HW must hold H_TOTAL-1 and VW must hold V_TOTAL-1. Comparisons are unsigned; no overflow past TOTAL-1 is possible.
- One frame = H_TOTAL*V_TOTAL*CLK_DIV = 1,385,280 clk cycles at defaults.

Test Plan:
- Reset then release, en=1 → all outputs at reset values; first pix_tick on 2nd edge with hcount=1; ticks every 2 clks thereafter.
- Run to hcount=855 → next tick hsync=0 at hcount=856; hsync returns to 1 at hcount=976; active=0 from hcount=800 to 1039.
- hcount=1039, vcount=10, then tick → hcount=0, vcount=11, line_start=1 for one clk, frame_start=0, active=1.
- hcount=1039, vcount=665, then tick → (0,0), line_start=frame_start=1 for one clk; frame_start period measured = 1,385,280 clks. vsync=0 exactly for vcount 637..642.
- en=0 for 7 clks starting on a tick cycle → counters frozen, no pulses; on resume the next tick occurs after the remaining divider count.
- Assert rst asynchronously mid-clock at (500,300) → outputs reset before the next edge; after release, sequence matches the first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider and raster counters with registered sync, active and line/frame markers
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned HW       = 11,
    parameter int unsigned VW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_tick,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] D_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_ON   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_ON   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_cnt, div_nxt;
    logic          div_last, h_last, v_last;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;

    // next divider and raster position; outputs are decoded from these so nothing lags the counters
    always_comb begin
        div_last = div_cnt == D_LAST;
        div_nxt  = div_last ? '0 : div_cnt + 1'b1;
        h_last   = hcount == H_LAST;
        v_last   = vcount == V_LAST;
        h_nxt    = h_last ? '0 : hcount + 1'b1;
        v_nxt    = h_last ? (v_last ? '0 : vcount + 1'b1) : vcount;
    end

    // divider, counters and registered outputs; pulses clear every edge, everything else holds while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            pix_tick    <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            active      <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                div_cnt <= div_nxt;
                if (div_last) begin
                    pix_tick    <= 1'b1;
                    hcount      <= h_nxt;
                    vcount      <= v_nxt;
                    active      <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
                    hsync       <= (h_nxt >= HS_ON && h_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
                    vsync       <= (v_nxt >= VS_ON && v_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
                    line_start  <= h_last;
                    frame_start <= h_last && v_last;
                end
            end
        end
    end
endmodule
